// File: rtl/accum_cpu_core.sv
// accum_cpu_core: accumulator CPU with fetch/decode/execute FSM, PC, IR, MBR and AC.
// Define ACPU_INDIRECT_EN to make operand bit [ADDR_WIDTH-1] an indirect-address flag.
module accum_cpu_core #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  halted,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] ac_o,
    output logic [DATA_WIDTH-1:0] ir_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_FWAIT,
        S_DECODE,
        S_IND,
        S_IWAIT,
        S_OPRD,
        S_OWAIT,
        S_STORE,
        S_EXEC,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_AND   = 4'h5;
    localparam logic [3:0] OP_OR    = 4'h6;
    localparam logic [3:0] OP_NOT   = 4'h7;
    localparam logic [3:0] OP_BACK  = 4'h8;
    localparam logic [3:0] OP_SKIP  = 4'h9;
    localparam logic [3:0] OP_JUMP  = 4'hA;
    localparam logic [3:0] OP_CLEAR = 4'hB;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t                state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] ea;
    logic [DATA_WIDTH-1:0] ir;
    logic [DATA_WIDTH-1:0] mbr;
    logic [DATA_WIDTH-1:0] ac;
    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] direct_addr;
    logic                  skip_taken;

    assign opcode = ir[DATA_WIDTH-1 -: 4];

`ifdef ACPU_INDIRECT_EN
    logic is_ind;
    assign direct_addr = {1'b0, ir[ADDR_WIDTH-2:0]};
    assign is_ind      = ir[ADDR_WIDTH-1] &&
                         (((opcode >= OP_LOAD) && (opcode <= OP_NOT)) || (opcode == OP_JUMP));
`else
    assign direct_addr = ir[ADDR_WIDTH-1:0];
`endif

    // Where an instruction goes once its effective address is known.
    function automatic state_t dispatch(input logic [3:0] op);
        case (op)
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT: dispatch = S_OPRD;
            OP_STORE: dispatch = S_STORE;
            OP_HALT:  dispatch = S_HALT;
            default:  dispatch = S_EXEC;
        endcase
    endfunction

    always_comb begin
        case (ir[ADDR_WIDTH-1 -: 2])
            2'b00:   skip_taken = ac[DATA_WIDTH-1];
            2'b01:   skip_taken = (ac == '0);
            2'b10:   skip_taken = !ac[DATA_WIDTH-1] && (ac != '0);
            default: skip_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            ea     <= '0;
            ir     <= '0;
            mbr    <= '0;
            ac     <= '0;
            halted <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc    <= RESET_PC;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_FWAIT;
                S_FWAIT: begin
                    ir    <= mem_rdata;
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    pc <= pc + ADDR_WIDTH'(1);
                    ea <= direct_addr;
                    if (opcode == OP_HALT) halted <= 1'b1;
`ifdef ACPU_INDIRECT_EN
                    state <= is_ind ? S_IND : dispatch(opcode);
`else
                    state <= dispatch(opcode);
`endif
                end
`ifdef ACPU_INDIRECT_EN
                S_IND: state <= S_IWAIT;
                S_IWAIT: begin
                    ea    <= mem_rdata[ADDR_WIDTH-1:0];
                    state <= dispatch(opcode);
                end
`endif
                S_OPRD: state <= S_OWAIT;
                S_OWAIT: begin
                    mbr   <= mem_rdata;
                    state <= S_EXEC;
                end
                S_STORE: state <= S_FETCH;
                S_EXEC: begin
                    // PC already points past this instruction, so BACK subtracts 2.
                    case (opcode)
                        OP_LOAD:  ac <= mbr;
                        OP_ADD:   ac <= ac + mbr;
                        OP_SUB:   ac <= ac - mbr;
                        OP_AND:   ac <= ac & mbr;
                        OP_OR:    ac <= ac | mbr;
                        OP_NOT:   ac <= ~mbr;
                        OP_BACK:  pc <= pc - ADDR_WIDTH'(2);
                        OP_SKIP:  if (skip_taken) pc <= pc + ADDR_WIDTH'(1);
                        OP_JUMP:  pc <= ea;
                        OP_CLEAR: ac <= '0;
                        default:  ;
                    endcase
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Memory strobes follow the state alone, so an async reset drops them at once.
    always_comb begin
        mem_addr = '0;
        mem_cs   = 1'b0;
        mem_we   = 1'b0;
        mem_oe   = 1'b0;
        case (state)
            S_FETCH: begin
                mem_addr = pc;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_IND: begin
                mem_addr = direct_addr;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_OPRD: begin
                mem_addr = ea;
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
            end
            S_STORE: begin
                mem_addr = ea;
                mem_cs   = 1'b1;
                mem_we   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_wdata = ac;
    assign pc_o      = pc;
    assign ac_o      = ac;
    assign ir_o      = ir;

endmodule
